// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared types, funct3 encodings and helpers for the MW-stage LSU.
// Revision : 1.0
// ============================================================================
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int CNT_W = 8;
  localparam int BE_W  = 4;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mw_lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : mw_lsu_if
// Brief    : Data-memory request/response bus between the LSU and memory.
// Revision : 1.0
// ============================================================================
interface mw_lsu_if;

  logic                      req_valid_o;
  logic                      req_ready_i;
  logic [31:0]               req_addr_o;
  logic                      req_we_o;
  logic [lsu_pkg::BE_W-1:0]  req_be_o;
  logic [31:0]               req_wdata_o;
  logic                      rsp_valid_i;
  logic [31:0]               rsp_rdata_i;

  modport master (
    output req_valid_o, req_addr_o, req_we_o, req_be_o, req_wdata_o,
    input  req_ready_i, rsp_valid_i, rsp_rdata_i
  );

  modport slave (
    input  req_valid_o, req_addr_o, req_we_o, req_be_o, req_wdata_o,
    output req_ready_i, rsp_valid_i, rsp_rdata_i
  );

endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Brief    : Access legality check, store lane generation and load formatting.
// Revision : 1.0
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]      i_f3,
  input  logic [1:0]      i_addr_lo,
  input  logic            i_we,
  input  logic [31:0]     i_wdata,
  output logic [BE_W-1:0] o_be,
  output logic [31:0]     o_wdata,
  output logic            o_err,
  input  logic [2:0]      i_ld_f3,
  input  logic [1:0]      i_ld_off,
  input  logic [31:0]     i_rdata,
  output logic [31:0]     o_ld_data
);

  logic        w_misalign;
  logic        w_f3_ok;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Loads read the whole word; only stores narrow the byte enables.
  always_comb begin
    o_be    = '1;
    o_wdata = '0;
    if (i_we) begin
      case (i_f3[1:0])
        2'b00: begin
          o_be    = BE_W'(1) << i_addr_lo;
          o_wdata = {4{i_wdata[7:0]}};
        end
        2'b01: begin
          o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
          o_wdata = {2{i_wdata[15:0]}};
        end
        default: o_wdata = i_wdata;
      endcase
    end
  end

  always_comb begin
    w_misalign = ((i_f3[1:0] == 2'b01) & i_addr_lo[0]) |
                 ((i_f3[1:0] == 2'b10) & (i_addr_lo != 2'b00));
    case (i_f3)
      F3_LB, F3_LH, F3_LW: w_f3_ok = 1'b1;
      F3_LBU, F3_LHU:      w_f3_ok = ~i_we;
      default:             w_f3_ok = 1'b0;
    endcase
    o_err = w_misalign | ~w_f3_ok;
  end

  always_comb begin
    case (i_ld_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_ld_f3)
      F3_LB:   o_ld_data = ext8(w_byte, 1'b1);
      F3_LH:   o_ld_data = ext16(w_half, 1'b1);
      F3_LW:   o_ld_data = i_rdata;
      F3_LBU:  o_ld_data = ext8(w_byte, 1'b0);
      F3_LHU:  o_ld_data = ext16(w_half, 1'b0);
      default: o_ld_data = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mw_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mw_lsu
// Brief    : MW-stage load/store unit: bus handshake FSM, stall and timeout.
// Revision : 1.0
// ============================================================================
module mw_lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  mw_lsu_if.master    bus,
  output logic        stall_mw_o,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        addr_err_o,
  output logic        bus_err_o
);

  localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

  lsu_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [29:0]      r_addr;
  logic             r_we;
  logic [BE_W-1:0]  r_be;
  logic [31:0]      r_wdata;
  logic [2:0]       r_f3;
  logic [1:0]       r_off;

  logic             w_access, w_we, w_chk_err, w_capture, w_timeout, w_req;
  logic [BE_W-1:0]  w_be;
  logic [31:0]      w_wdata, w_ld_data;

  assign w_access  = mem_rd_i | mem_wr_i;
  assign w_we      = mem_wr_i & ~mem_rd_i;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  // Compare against the incremented count so the error lands on the Nth RESP cycle.
  assign w_timeout = (w_cnt_inc == c_TIMEOUT);

  lsu_align u_align (
    .i_f3      (funct3_i),
    .i_addr_lo (addr_i[1:0]),
    .i_we      (w_we),
    .i_wdata   (wdata_i),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .o_err     (w_chk_err),
    .i_ld_f3   (r_f3),
    .i_ld_off  (r_off),
    .i_rdata   (bus.rsp_rdata_i),
    .o_ld_data (w_ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
      r_f3    <= '0;
      r_off   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_addr  <= addr_i[31:2];
        r_we    <= w_we;
        r_be    <= w_be;
        r_wdata <= w_wdata;
        r_f3    <= funct3_i;
        r_off   <= addr_i[1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = '0;
    w_capture    = 1'b0;
    stall_mw_o   = 1'b0;
    addr_err_o   = 1'b0;
    bus_err_o    = 1'b0;
    load_valid_o = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_access) begin
          if (w_chk_err) begin
            addr_err_o = 1'b1;
          end else begin
            w_capture   = 1'b1;
            stall_mw_o  = 1'b1;
            w_state_nxt = REQ;
          end
        end
      end
      REQ: begin
        stall_mw_o = 1'b1;
        if (bus.req_ready_i) w_state_nxt = RESP;
      end
      RESP: begin
        // Completion drops stall so the MW register advances on this edge.
        if (bus.rsp_valid_i) begin
          load_valid_o = ~r_we;
          w_state_nxt  = IDLE;
        end else if (w_timeout) begin
          bus_err_o   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          stall_mw_o = 1'b1;
          w_cnt_nxt  = w_cnt_inc;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_req           = (r_state == REQ);
  assign bus.req_valid_o = w_req;
  assign bus.req_addr_o  = w_req ? {r_addr, 2'b00} : '0;
  assign bus.req_we_o    = w_req & r_we;
  assign bus.req_be_o    = w_req ? r_be : '0;
  assign bus.req_wdata_o = w_req ? r_wdata : '0;
  assign load_data_o     = load_valid_o ? w_ld_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_mw_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mw_lsu
// Brief    : Scoreboard bench for mw_lsu with directed load/store vectors.
// Revision : 1.0
// ============================================================================
module tb_mw_lsu;
  import lsu_pkg::*;

  localparam int T_OUT  = 4;
  localparam int K_REQ  = 0;
  localparam int K_LOAD = 1;
  localparam int K_AERR = 2;
  localparam int K_BERR = 3;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_rd = 1'b0, mem_wr = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr_in = '0, wdata_in = '0;
  logic        stall_mw, load_valid, addr_err, bus_err;
  logic [31:0] load_data;

  int   vectors = 0;
  int   miscompares = 0;
  int   stall_cnt = 0;
  exp_t q[$];

  mw_lsu_if bus();

  mw_lsu #(.TIMEOUT_CYCLES(T_OUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_rd_i     (mem_rd),
    .mem_wr_i     (mem_wr),
    .funct3_i     (funct3),
    .addr_i       (addr_in),
    .wdata_i      (wdata_in),
    .bus          (bus),
    .stall_mw_o   (stall_mw),
    .load_data_o  (load_data),
    .load_valid_o (load_valid),
    .addr_err_o   (addr_err),
    .bus_err_o    (bus_err)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endfunction

  // Monitor: pops expectations whenever the DUT presents an event.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.req_valid_o) begin
          if (q.size() == 0 || q[0].kind != K_REQ) check("unexpected_req", 32'd1, 32'd0);
          else begin
            e = q[0];
            check("req_addr",  bus.req_addr_o, e.addr);
            check("req_we",    32'(bus.req_we_o), 32'(e.we));
            check("req_be",    32'(bus.req_be_o), 32'(e.be));
            check("req_wdata", bus.req_wdata_o, e.data);
            if (bus.req_ready_i) void'(q.pop_front());
          end
        end else if (bus.req_addr_o != 0 || bus.req_be_o != 0 || bus.req_wdata_o != 0 || bus.req_we_o)
          check("req_idle_zero", bus.req_addr_o | 32'(bus.req_be_o), 32'd0);
        if (load_valid) begin
          if (q.size() == 0 || q[0].kind != K_LOAD) check("unexpected_load", 32'd1, 32'd0);
          else begin
            e = q.pop_front();
            check("load_data", load_data, e.data);
          end
        end else if (load_data != 0) check("load_data_idle", load_data, 32'd0);
        if (addr_err) begin
          if (q.size() == 0 || q[0].kind != K_AERR) check("unexpected_addr_err", 32'd1, 32'd0);
          else begin void'(q.pop_front()); check("addr_err", 32'd1, 32'd1 & 32'(addr_err)); end
        end
        if (bus_err) begin
          if (q.size() == 0 || q[0].kind != K_BERR) check("unexpected_bus_err", 32'd1, 32'd0);
          else begin void'(q.pop_front()); check("bus_err_stall", 32'(stall_mw), 32'd0); end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    if (stall_mw) stall_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] d);
    exp_t e;
    e.kind = k; e.addr = a; e.we = we; e.be = be; e.data = d;
    q.push_back(e);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    mem_rd = rd; mem_wr = wr; funct3 = f3; addr_in = a; wdata_in = wd;
  endtask

  task automatic access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input int rdy_dly, input int rsp_dly, input logic [31:0] rdata,
                        input logic [31:0] exp_ld, input int exp_stall, input logic tmo, input logic early);
    push(K_REQ, {a[31:2], 2'b00}, wr & ~rd, exp_be, exp_wd);
    if (tmo) push(K_BERR, '0, 1'b0, '0, '0);
    else if (rd) push(K_LOAD, '0, 1'b0, '0, exp_ld);
    drive(rd, wr, f3, a, wd);
    stall_cnt = 0;
    step();
    for (int i = 0; i < rdy_dly; i++) step();
    bus.req_ready_i = 1'b1;
    if (early) begin bus.rsp_valid_i = 1'b1; bus.rsp_rdata_i = 32'hBAD0BAD0; end
    step();
    bus.req_ready_i = 1'b0; bus.rsp_valid_i = 1'b0; bus.rsp_rdata_i = '0;
    if (tmo) begin
      for (int i = 0; i < T_OUT; i++) step();
    end else begin
      for (int i = 0; i < rsp_dly; i++) step();
      bus.rsp_valid_i = 1'b1; bus.rsp_rdata_i = rdata;
      step();
      bus.rsp_valid_i = 1'b0; bus.rsp_rdata_i = '0;
    end
    drive(0, 0, 3'b000, '0, '0);
    check("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
  endtask

  task automatic bad_access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
    push(K_AERR, '0, 1'b0, '0, '0);
    drive(rd, wr, f3, a, 32'h12345678);
    stall_cnt = 0;
    @(negedge clk);
    check("aerr_stall", 32'(stall_mw), 32'd0);
    @(posedge clk); #1;
    drive(0, 0, 3'b000, '0, '0);
    step(); step();
    check("aerr_no_stall", 32'(stall_cnt), 32'd0);
  endtask

  initial begin
    bus.req_ready_i = 1'b0; bus.rsp_valid_i = 1'b0; bus.rsp_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_valid",  32'(bus.req_valid_o), 32'd0);
    check("rst_stall",      32'(stall_mw), 32'd0);
    check("rst_load_valid", 32'(load_valid), 32'd0);
    check("rst_errs",       32'({addr_err, bus_err}), 32'd0);
    @(posedge clk); #1;

    // Word load, rsp two cycles into RESP.
    access(1,0,F3_LW, 32'h100, '0, 4'hF, '0, 0, 2, 32'hDEADBEEF, 32'hDEADBEEF, 4, 0, 0);
    // Sub-word loads from lane 3 / upper half.
    access(1,0,F3_LB,  32'h203, '0, 4'hF, '0, 0, 0, 32'h80112233, 32'hFFFFFF80, 2, 0, 0);
    access(1,0,F3_LBU, 32'h203, '0, 4'hF, '0, 0, 1, 32'h80112233, 32'h00000080, 3, 0, 1);
    access(1,0,F3_LHU, 32'h202, '0, 4'hF, '0, 0, 0, 32'h80112233, 32'h00008011, 2, 0, 0);
    access(1,0,F3_LH,  32'h200, '0, 4'hF, '0, 0, 0, 32'h80112233, 32'h00002233, 2, 0, 0);
    access(1,0,F3_LB,  32'h201, '0, 4'hF, '0, 0, 0, 32'h80112233, 32'h00000022, 2, 0, 0);
    // Stores wait for ack.
    access(0,1,F3_LB, 32'h7,  32'h000000A5, 4'b1000, 32'hA5A5A5A5, 0, 1, '0, '0, 3, 0, 0);
    access(0,1,F3_LH, 32'h6,  32'h0000BEEF, 4'b1100, 32'hBEEFBEEF, 0, 0, '0, '0, 2, 0, 0);
    access(0,1,F3_LW, 32'h10, 32'h01234567, 4'b1111, 32'h01234567, 0, 0, '0, '0, 2, 0, 0);
    // Illegal accesses.
    bad_access(1,0,F3_LW,  32'h102);
    bad_access(1,0,F3_LH,  32'h101);
    bad_access(0,1,F3_LBU, 32'h0);
    // Ready held low, then timeout with no response.
    access(1,0,F3_LW, 32'h300, '0, 4'hF, '0, 5, 0, 32'h12345678, 32'h12345678, 7, 0, 0);
    access(1,0,F3_LW, 32'h304, '0, 4'hF, '0, 0, 0, '0, '0, 5, 1, 0);
    // Reset in RESP, then a late response.
    push(K_REQ, 32'h400, 1'b0, 4'hF, '0);
    drive(1, 0, F3_LW, 32'h400, '0);
    step();
    bus.req_ready_i = 1'b1; step(); bus.req_ready_i = 1'b0;
    step();
    rst = 1'b1; drive(0, 0, 3'b000, '0, '0); step(); rst = 1'b0;
    bus.rsp_valid_i = 1'b1; bus.rsp_rdata_i = 32'h55AA55AA; step();
    bus.rsp_valid_i = 1'b0; bus.rsp_rdata_i = '0;
    @(negedge clk);
    check("post_rst_stall", 32'(stall_mw), 32'd0);
    @(posedge clk); #1;
    // Back-to-back load then store.
    access(1,0,F3_LW, 32'h500, '0, 4'hF, '0, 0, 0, 32'hCAFEF00D, 32'hCAFEF00D, 2, 0, 0);
    access(0,1,F3_LW, 32'h504, 32'h11112222, 4'hF, 32'h11112222, 0, 0, '0, '0, 2, 0, 0);
    repeat (3) step();
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mw_lsu.md
# mw_lsu

Load/store unit for the memory/writeback (MW) stage of the 3-stage RV32I pipeline. It consumes the MW pipeline register outputs (effective address, store data, access controls), runs a valid/ready request plus response handshake to the data-memory bus, formats load data, and drives `stall_mw_o` back to the MW register and the front-end while an access is outstanding. Misaligned or unsupported accesses and bus timeouts are flagged rather than issued or hung.

## Interface
- `TIMEOUT_CYCLES`, default 255. Cycles waited in RESP before a bus error; 1..255.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `mem_rd_i` input 1: MW instruction is a load.
- `mem_wr_i` input 1: MW instruction is a store. Both set is illegal; load wins.
- `funct3_i` input 3: RV32I size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `addr_i` input 32: effective address (`ALUResult_MW`).
- `wdata_i` input 32: store source (`rdata2_MW`).
- `req_valid_o` output 1: bus request valid.
- `req_ready_i` input 1: bus accepts the request.
- `req_addr_o` output 32: word-aligned address, `{addr[31:2],2'b00}`.
- `req_we_o` output 1: 1 = write.
- `req_be_o` output 4: byte enables.
- `req_wdata_o` output 32: lane-replicated store data.
- `rsp_valid_i` input 1: response/ack valid, one cycle.
- `rsp_rdata_i` input 32: read data, valid with `rsp_valid_i`.
- `stall_mw_o` output 1: hold the MW register and upstream.
- `load_data_o` output 32: formatted load result.
- `load_valid_o` output 1: `load_data_o` valid this cycle; write back to rd.
- `addr_err_o` output 1: one-cycle pulse, misaligned or unsupported funct3.
- `bus_err_o` output 1: one-cycle pulse, response timeout.

## Operation
- States: IDLE, REQ, RESP.
- IDLE: access = `mem_rd_i | mem_wr_i`. Checks: H with `addr[0]`=1, W with `addr[1:0]`≠0, or funct3 ∉ {000,001,010,100,101} for loads / ∉ {000,001,010} for stores. Failed check: pulse `addr_err_o`, no request, no stall, stay IDLE. Valid access: capture addr, `we`, be, wdata, funct3, `addr[1:0]`; `stall_mw_o`=1 combinationally; go to REQ.
- REQ: `req_valid_o`=1 with captured fields held stable until `req_ready_i`; on handshake go to RESP, clear timeout counter.
- RESP: counter increments each cycle without `rsp_valid_i`. `rsp_valid_i` → complete: loads assert `load_valid_o` and `load_data_o` in that cycle; `stall_mw_o`=0; go to IDLE. Counter reaching `TIMEOUT_CYCLES` → `bus_err_o` pulse, `load_valid_o`=0, `stall_mw_o`=0, go to IDLE.
- `rsp_valid_i` arriving in the same cycle as the REQ handshake is ignored; a response counts only in RESP.
- Stores wait for ack exactly like loads; `load_valid_o` stays 0.
- Byte enables: B → `1<<addr[1:0]`, wdata `{4{wdata[7:0]}}`. H → `addr[1]` ? 1100 : 0011, wdata `{2{wdata[15:0]}}`. W → 1111, wdata unchanged. Loads: `req_be_o`=1111.
- Load formatting selects the lane by captured `addr[1:0]`. B/H sign-extend, BU/HU zero-extend, W passes through.
- Outputs are 0 when not active: `req_*` 0 outside REQ, `load_data_o` 0 when `load_valid_o`=0.

## Timing
- Reset: state IDLE, counter 0, all captured registers 0. All outputs 0 except `stall_mw_o`, which follows IDLE combinational logic. Reset mid-REQ or mid-RESP aborts; any later `rsp_valid_i` is ignored in IDLE.
- Minimum access: IDLE (stall) → REQ, ready=1 → RESP, rsp=1. That is 3 cycles with stall high for 2.
- Completion cycle has stall low, so the MW register loads the next instruction at that edge. The FSM is back in IDLE in the following cycle, and a back-to-back access gets no idle bubble.
- Timeout fires in the cycle the counter equals `TIMEOUT_CYCLES`, i.e. after `TIMEOUT_CYCLES` RESP cycles.

## Structure
- `lsu_pkg`: `lsu_state_e` {IDLE, REQ, RESP}; funct3 constants `F3_LB`…`F3_LHU`; widths of counter and be.
- Sub-module `lsu_align`: combinational be/wdata generation, access check, and load formatting. `mw_lsu` holds the FSM, capture registers and counter.

## Test plan
- LW, addr 0x100, ready immediate, rsp after 2 cycles with 0xDEADBEEF → `req_addr_o`=0x100, be 1111, `load_data_o`=0xDEADBEEF with `load_valid_o`, stall high 4 cycles.
- LB addr 0x203 with rsp 0x80112233 → 0xFFFFFF80; LBU → 0x00000080; LHU addr 0x202 → 0x00008011.
- SB addr 0x7, wdata 0x000000A5 → be 1000, wdata 0xA5A5A5A5, we=1; SH addr 0x6 → be 1100.
- LW addr 0x102 → `addr_err_o` one pulse, `req_valid_o` never set, stall never set.
- `req_ready_i` low for 5 cycles → request fields stable, then handshake. With `TIMEOUT_CYCLES`=4 and no rsp → `bus_err_o` pulse on the 4th RESP cycle, stall drops.
- `rst` asserted in RESP, then late `rsp_valid_i` → IDLE, no `load_valid_o`. Back-to-back LW/SW → second request one cycle after first completion.
